// File: rtl/connect4_turn_timer.sv
// Purpose : per-turn countdown for Connect-4; reloads on entry to PLAYER_TURN, pulses times_up on expiry.
// Latency : all outputs registered; they reflect inputs sampled on the previous clk edge (async reset clears at once).
// Backpressure: none; times_up is a single-cycle pulse with no handshake, the controller must catch it.
//
// Ports:
//   clk, reset            - system clock, asynchronous active-high reset
//   game_state[2:0]       - controller state code (1 = PLAYER_TURN, 5 = GAME_OVER)
//   timer_enable          - level; 0 stops counting and suppresses expiry
//   times_up              - one-cycle expiry pulse
//   running               - high while the countdown is active
//   seconds_left[6:0]     - remaining whole seconds, binary
//   bcd_tens/bcd_ones     - decimal digits of seconds_left
//   warning               - running with seconds_left <= WARN_SECONDS
module connect4_turn_timer #(
   parameter int CLK_HZ       = 50_000_000,
   parameter int TURN_SECONDS = 15,
   parameter int WARN_SECONDS = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] game_state,
   input  logic       timer_enable,
   output logic       times_up,
   output logic       running,
   output logic [6:0] seconds_left,
   output logic [3:0] bcd_tens,
   output logic [3:0] bcd_ones,
   output logic       warning
);

   localparam int            PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0] PRE_TC    = PW'(CLK_HZ - 1);
   localparam logic [6:0]    LOAD_SEC  = 7'(TURN_SECONDS);
   localparam logic [3:0]    LOAD_TENS = 4'(TURN_SECONDS / 10);
   localparam logic [3:0]    LOAD_ONES = 4'(TURN_SECONDS % 10);
   localparam logic [6:0]    WARN_SEC  = 7'(WARN_SECONDS);
   localparam logic [2:0]    GS_TURN   = 3'd1;
   localparam logic [2:0]    GS_OVER   = 3'd5;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUNNING = 2'd1,
      EXPIRED = 2'd2,
      HALTED  = 2'd3
   } state_t;

   state_t        state, state_nxt;
   logic [2:0]    prev_state;
   logic [PW-1:0] pre, pre_nxt;
   logic [6:0]    sec_nxt;
   logic [3:0]    tens_nxt, ones_nxt;
   logic          tu_nxt;
   logic          in_turn, over, entry, tick;

   assign in_turn = (game_state == GS_TURN);
   assign over    = (game_state == GS_OVER);
   // prev_state resets to 0, so a game_state already at 1 out of reset is an entry.
   assign entry   = in_turn && (prev_state != GS_TURN);
   assign tick    = (pre == PRE_TC);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      pre_nxt   = pre;
      sec_nxt   = seconds_left;
      tens_nxt  = bcd_tens;
      ones_nxt  = bcd_ones;
      tu_nxt    = 1'b0;
      case (state)
         IDLE: begin
            if (over) begin
               state_nxt = HALTED;
            end else if (entry && timer_enable) begin
               state_nxt = RUNNING;
               pre_nxt   = '0;
               sec_nxt   = LOAD_SEC;
               tens_nxt  = LOAD_TENS;
               ones_nxt  = LOAD_ONES;
            end
         end
         RUNNING: begin
            // GAME_OVER beats leave/disable, which beats the tick: an expiry
            // tick on the same edge as a leave is dropped with no pulse.
            if (over) begin
               state_nxt = HALTED;
               pre_nxt   = '0;
            end else if (!in_turn || !timer_enable) begin
               state_nxt = IDLE;
               pre_nxt   = '0;
            end else if (tick) begin
               pre_nxt = '0;
               sec_nxt = seconds_left - 7'd1;
               if (bcd_ones == 4'd0) begin
                  ones_nxt = 4'd9;
                  tens_nxt = bcd_tens - 4'd1;
               end else begin
                  ones_nxt = bcd_ones - 4'd1;
               end
               if (seconds_left == 7'd1) begin
                  state_nxt = EXPIRED;
                  tu_nxt    = 1'b1;
               end
            end else begin
               pre_nxt = pre + 1'b1;
            end
         end
         EXPIRED: begin
            if (!in_turn) begin
               state_nxt = over ? HALTED : IDLE;
            end
         end
         HALTED: begin
            // Frozen until reset.
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_state   <= 3'd0;
         pre          <= '0;
         seconds_left <= 7'd0;
         bcd_tens     <= 4'd0;
         bcd_ones     <= 4'd0;
         times_up     <= 1'b0;
         running      <= 1'b0;
         warning      <= 1'b0;
      end else begin
         prev_state   <= game_state;
         pre          <= pre_nxt;
         seconds_left <= sec_nxt;
         bcd_tens     <= tens_nxt;
         bcd_ones     <= ones_nxt;
         times_up     <= tu_nxt;
         running      <= (state_nxt == RUNNING);
         warning      <= (state_nxt == RUNNING) && (sec_nxt <= WARN_SEC);
      end
   end

endmodule

// File: tb/tb_connect4_turn_timer.sv
// Purpose : checks connect4_turn_timer (two parameter sets) against a cycle-level model plus directed literals.
// Latency : model updates on the same clk edge as the DUT; outputs compared on the following negedge.
// Backpressure: none.
module tb_connect4_turn_timer;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] gs;
   logic       en;

   logic       tu_a, run_a, warn_a, tu_b, run_b, warn_b;
   logic [6:0] sec_a, sec_b;
   logic [3:0] tens_a, ones_a, tens_b, ones_b;

   int errors = 0;
   int checks = 0;
   int rel    = 0;
   bit cmp_on = 1'b0;

   // Model state, index 0 = instance a, 1 = instance b.
   int         m_sec [2];
   int         m_el  [2];
   bit         m_cnt [2];
   bit         m_halt[2];
   bit         m_tu  [2];
   logic [2:0] m_prev = 3'd0;

   always #5 clk = ~clk;

   connect4_turn_timer #(.CLK_HZ(4), .TURN_SECONDS(3), .WARN_SECONDS(1)) u_a (
      .clk(clk), .reset(reset), .game_state(gs), .timer_enable(en),
      .times_up(tu_a), .running(run_a), .seconds_left(sec_a),
      .bcd_tens(tens_a), .bcd_ones(ones_a), .warning(warn_a));

   connect4_turn_timer #(.CLK_HZ(2), .TURN_SECONDS(12), .WARN_SECONDS(3)) u_b (
      .clk(clk), .reset(reset), .game_state(gs), .timer_enable(en),
      .times_up(tu_b), .running(run_b), .seconds_left(sec_b),
      .bcd_tens(tens_b), .bcd_ones(ones_b), .warning(warn_b));

   function automatic int hz(input int i);
      return (i == 0) ? 4 : 2;
   endfunction
   function automatic int tsec(input int i);
      return (i == 0) ? 3 : 12;
   endfunction
   function automatic int wsec(input int i);
      return (i == 0) ? 1 : 3;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Remaining seconds = limit minus whole seconds elapsed since the entry edge.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_prev <= 3'd0;
         for (int i = 0; i < 2; i++) begin
            m_sec[i]  <= 0;
            m_el[i]   <= 0;
            m_cnt[i]  <= 1'b0;
            m_halt[i] <= 1'b0;
            m_tu[i]   <= 1'b0;
         end
      end else begin
         m_prev <= gs;
         for (int i = 0; i < 2; i++) begin
            automatic int s = m_sec[i];
            automatic int e = m_el[i];
            automatic bit c = m_cnt[i];
            automatic bit h = m_halt[i];
            automatic bit t = 1'b0;
            if (!h) begin
               if (gs == 3'd5) begin
                  h = 1'b1;
                  c = 1'b0;
               end else if (c) begin
                  if (gs != 3'd1 || !en) begin
                     c = 1'b0;
                  end else begin
                     e = e + 1;
                     s = tsec(i) - e / hz(i);
                     if (s == 0) begin
                        c = 1'b0;
                        t = 1'b1;
                     end
                  end
               end else if (gs == 3'd1 && m_prev != 3'd1 && en) begin
                  c = 1'b1;
                  e = 0;
                  s = tsec(i);
               end
            end
            m_sec[i]  <= s;
            m_el[i]   <= e;
            m_cnt[i]  <= c;
            m_halt[i] <= h;
            m_tu[i]   <= t;
         end
      end
   end

   task automatic check_inst(input string p, input int i, input logic tu, input logic run,
                             input logic [6:0] s, input logic [3:0] t, input logic [3:0] o,
                             input logic w);
      chk({p, ".times_up"}, tu, m_tu[i]);
      chk({p, ".running"}, run, m_cnt[i]);
      chk({p, ".seconds_left"}, s, m_sec[i]);
      chk({p, ".bcd_tens"}, t, m_sec[i] / 10);
      chk({p, ".bcd_ones"}, o, m_sec[i] % 10);
      chk({p, ".warning"}, w, m_cnt[i] && (m_sec[i] <= wsec(i)));
   endtask

   always @(negedge clk) begin
      if (cmp_on) begin
         check_inst("a", 0, tu_a, run_a, sec_a, tens_a, ones_a, warn_a);
         check_inst("b", 1, tu_b, run_b, sec_b, tens_b, ones_b, warn_b);
      end
   end

   task automatic pulse_reset();
      @(posedge clk);
      #2 reset = 1'b1;
      @(posedge clk);
      #2 reset = 1'b0;
   endtask

   // Leaves the bench at the negedge just after entry edge E0, rel = 0.
   task automatic start_turn();
      gs = 3'd0;
      en = 1'b1;
      pulse_reset();
      @(negedge clk);
      gs = 3'd1;
      @(negedge clk);
      rel = 0;
   endtask

   task automatic go(input int k);
      while (rel < k) begin
         @(negedge clk);
         rel++;
      end
   endtask

   initial begin
      reset = 1'b1;
      gs    = 3'd0;
      en    = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      chk("rst.sec_a", sec_a, 0);
      chk("rst.run_a", run_a, 0);
      chk("rst.tu_a", tu_a, 0);
      chk("rst.digits_b", {tens_b, ones_b}, 0);
      reset  = 1'b0;
      cmp_on = 1'b1;

      // Basic expiry on a, BCD borrow on b.
      start_turn();
      chk("s1.sec_a_e0", sec_a, 3);
      chk("s1.run_a_e0", run_a, 1);
      chk("s1.bcd_b_e0", {tens_b, ones_b}, 8'h12);
      go(2);  chk("s1.bcd_b_e2", {tens_b, ones_b}, 8'h11);
      go(3);  chk("s1.sec_a_e3", sec_a, 3);
      go(4);  chk("s1.sec_a_e4", sec_a, 2);
              chk("s1.warn_a_e4", warn_a, 0);
              chk("s1.bcd_b_e4", {tens_b, ones_b}, 8'h10);
      go(6);  chk("s1.bcd_b_e6", {tens_b, ones_b}, 8'h09);
              chk("s1.sec_b_e6", sec_b, 9);
      go(8);  chk("s1.sec_a_e8", sec_a, 1);
              chk("s1.warn_a_e8", warn_a, 1);
      go(11); chk("s1.tu_a_e11", tu_a, 0);
      go(12); chk("s1.tu_a_e12", tu_a, 1);
              chk("s1.sec_a_e12", sec_a, 0);
              chk("s1.run_a_e12", run_a, 0);
              chk("s1.warn_a_e12", warn_a, 0);
      go(13); chk("s1.tu_a_e13", tu_a, 0);
      go(24); chk("s1.tu_b_e24", tu_b, 1);
              chk("s1.bcd_b_e24", {tens_b, ones_b}, 8'h00);

      // Leave and re-enter.
      start_turn();
      go(5);  gs = 3'd4;
      go(6);  chk("s2.sec_a_out", sec_a, 2);
              chk("s2.run_a_out", run_a, 0);
      go(7);  gs = 3'd1;
      go(8);  chk("s2.sec_a_reload", sec_a, 3);
              chk("s2.run_a_reload", run_a, 1);
      go(19); chk("s2.tu_a_e19", tu_a, 0);
      go(20); chk("s2.tu_a_e20", tu_a, 1);

      // Game over freezes the count.
      start_turn();
      go(4);  gs = 3'd5;
      go(5);  chk("s3.sec_a", sec_a, 2);
              chk("s3.run_a", run_a, 0);
      go(6);  gs = 3'd4;
      go(8);  gs = 3'd1;
      go(20); chk("s3.sec_a_late", sec_a, 2);
              chk("s3.run_a_late", run_a, 0);

      // Leave sampled on the expiry edge.
      start_turn();
      go(11); gs = 3'd4;
      go(12); chk("s4.tu_a", tu_a, 0);
              chk("s4.sec_a", sec_a, 1);
      go(13); chk("s4.tu_a_next", tu_a, 0);

      // Asynchronous reset mid-count.
      start_turn();
      go(4);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("s5.sec_a_rst", sec_a, 0);
      chk("s5.run_a_rst", run_a, 0);
      chk("s5.digits_a_rst", {tens_a, ones_a}, 0);
      chk("s5.warn_a_rst", warn_a, 0);
      @(posedge clk);
      #2 reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("s5.sec_a_reload", sec_a, 3);
      chk("s5.run_a_reload", run_a, 1);

      // Randomised play.
      gs = 3'd1;
      en = 1'b1;
      for (int n = 0; n < 5000; n++) begin
         @(negedge clk);
         if ($urandom_range(0, 29) == 0) begin
            case ($urandom_range(0, 9))
               0:             gs = 3'd0;
               1, 2, 3, 4, 5: gs = 3'd1;
               6:             gs = 3'd4;
               7:             gs = 3'd2;
               8:             gs = 3'($urandom_range(0, 7));
               default:       gs = ($urandom_range(0, 3) == 0) ? 3'd5 : 3'd1;
            endcase
         end
         if (en && $urandom_range(0, 99) == 0) en = 1'b0;
         else if (!en && $urandom_range(0, 5) == 0) en = 1'b1;
         if ($urandom_range(0, 249) == 0) pulse_reset();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
